sdram_pll_reset_sequencer: RTL

Supervises the SDRAM PLL and produces the design's reset and bring-up sequence. It drives the PLL reset and watches the PLL lock output. Once lock has been stable, it waits out the SDRAM power-up delay, then requests SDRAM initialisation from the controller. It releases system reset only after the controller acknowledges. It runs on the 50 MHz board reference clock that also feeds the PLL, so it keeps working when the PLL output clocks are invalid.

---
 rtl/sdram_pll_reset_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sdram_pll_reset_sequencer.sv
// PLL supervision and SDRAM bring-up sequencer on the board reference clock.
// Holds system reset until the PLL is locked, SDRAM has powered up and the controller has finished init.
module sdram_pll_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int POWERUP_CYCLES      = 5000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                               refclk,
    input  logic                               rst,
    output logic                               pll_rst,
    input  logic                               pll_locked,
    output logic                               sdram_init_req,
    input  logic                               sdram_init_ack,
    output logic                               sys_reset,
    output logic                               ready,
    output logic                               fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

    localparam int RW   = $clog2(MAX_RETRIES + 1);
    localparam int MAX1 = (LOCK_STABLE_CYCLES > LOCK_TIMEOUT_CYCLES) ? LOCK_STABLE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX2 = (PLL_RST_CYCLES > POWERUP_CYCLES) ? PLL_RST_CYCLES : POWERUP_CYCLES;
    localparam int CMAX = (MAX1 > MAX2) ? MAX1 : MAX2;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_POWERUP,
        S_INIT_REQ,
        S_RUN,
        S_FAIL
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [RW-1:0] retry_nxt;
    logic [1:0]    lock_sync, ack_sync;
    logic          locked_s, ack_s;

    assign locked_s = lock_sync[1];
    assign ack_s    = ack_sync[1];

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_sync <= '0;
            ack_sync  <= '0;
        end else begin
            lock_sync <= {lock_sync[0], pll_locked};
            ack_sync  <= {ack_sync[0], sdram_init_ack};
        end
    end

    // Lock loss is tested before any count-done or ack condition so it always wins.
    always_comb begin
        state_nxt = state;
        retry_nxt = retry_count;
        case (state)
            S_PLL_RST: begin
                if (cnt == CW'(PLL_RST_CYCLES - 1)) state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = S_STABLE;
                end else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    if (retry_count < RW'(MAX_RETRIES)) begin
                        retry_nxt = retry_count + RW'(1);
                        state_nxt = S_PLL_RST;
                    end else begin
                        state_nxt = S_FAIL;
                    end
                end
            end
            S_STABLE: begin
                if (!locked_s)                                  state_nxt = S_WAIT_LOCK;
                else if (cnt == CW'(LOCK_STABLE_CYCLES - 1))    state_nxt = S_POWERUP;
            end
            S_POWERUP: begin
                if (!locked_s)                                  state_nxt = S_PLL_RST;
                else if (cnt == CW'(POWERUP_CYCLES - 1))        state_nxt = S_INIT_REQ;
            end
            S_INIT_REQ: begin
                if (!locked_s) begin
                    state_nxt = S_PLL_RST;
                end else if (ack_s) begin
                    state_nxt = S_RUN;
                    retry_nxt = '0;
                end
            end
            S_RUN: begin
                if (!locked_s) state_nxt = S_PLL_RST;
            end
            S_FAIL:  state_nxt = S_FAIL;
            default: state_nxt = S_PLL_RST;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state          <= S_PLL_RST;
            cnt            <= '0;
            retry_count    <= '0;
            pll_rst        <= 1'b1;
            sys_reset      <= 1'b1;
            sdram_init_req <= 1'b0;
            ready          <= 1'b0;
            fail           <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= (state_nxt != state) ? '0 : cnt + CW'(1);
            retry_count    <= retry_nxt;
            pll_rst        <= (state_nxt == S_PLL_RST) || (state_nxt == S_FAIL);
            sys_reset      <= (state_nxt != S_RUN);
            sdram_init_req <= (state_nxt == S_INIT_REQ);
            ready          <= (state_nxt == S_RUN);
            fail           <= (state_nxt == S_FAIL);
        end
    end

endmodule
